// File: rtl/led_wall_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_wall_pkg
// Purpose  : Shared geometry constants and FSM state encoding for the LED wall.
// Revision : 1.0 - initial release
// ============================================================================
package led_wall_pkg;

    localparam int STRANDS = 8;
    localparam int LEDS    = 5;
    localparam int BPP     = 24;
    localparam int BITS    = LEDS * BPP;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_bank.sv
`default_nettype none
// ============================================================================
// Module   : frame_bank
// Purpose  : One frame buffer of STRANDS x BITS bits; GRB write by (strand, led)
//            and a combinational read of one bit column across all strands.
// Revision : 1.0 - initial release
// ============================================================================
module frame_bank #(
    parameter int STRANDS = led_wall_pkg::STRANDS,
    parameter int LEDS    = led_wall_pkg::LEDS,
    parameter int BPP     = led_wall_pkg::BPP
) (
    input  logic                              clk_in,
    input  logic                              ar,
    input  logic                              wr_en,
    input  logic [$clog2(STRANDS)-1:0]        wr_strand,
    input  logic [$clog2(LEDS)-1:0]           wr_led,
    input  logic [BPP-1:0]                    wr_grb,
    input  logic [$clog2(LEDS*BPP)-1:0]       rd_idx,
    output logic [STRANDS-1:0]                rd_col
);

    localparam int c_BITS = LEDS * BPP;
    localparam int c_IW   = $clog2(c_BITS);

    // LED0 occupies the top BPP bits, so the MSB of a pixel sits at BITS-1-led*BPP
    logic [c_IW-1:0] w_base;
    logic            w_led_ok;

    assign w_base   = c_IW'(c_BITS - 1 - int'(wr_led) * BPP);
    assign w_led_ok = int'(wr_led) < LEDS;

    for (genvar s = 0; s < STRANDS; s++) begin : g_strand
        logic [c_BITS-1:0] r_bits;
        logic              w_hit;

        assign w_hit = wr_en && w_led_ok && (int'(wr_strand) == s);

        always_ff @(posedge clk_in) begin
            if (!ar) begin
                r_bits <= '0;
            end else if (w_hit) begin
                r_bits[w_base -: BPP] <= wr_grb;
            end
        end

        assign rd_col[s] = r_bits[rd_idx];
    end

endmodule
`default_nettype wire

// File: rtl/frame_slicer.sv
`default_nettype none
// ============================================================================
// Module   : frame_slicer
// Purpose  : Double-buffered frame store streaming per-bit strand slices with
//            a valid/ready handshake and a programmable inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module frame_slicer #(
    parameter int STRANDS    = led_wall_pkg::STRANDS,
    parameter int LEDS       = led_wall_pkg::LEDS,
    parameter int BPP        = led_wall_pkg::BPP,
    parameter int GAP_CYCLES = 1000
) (
    input  logic                          clk_in,
    input  logic                          ar,
    input  logic                          wr_en,
    input  logic [$clog2(STRANDS)-1:0]    wr_strand,
    input  logic [$clog2(LEDS)-1:0]       wr_led,
    input  logic [BPP-1:0]                wr_grb,
    input  logic                          swap_req,
    output logic                          swap_pending,
    output logic [STRANDS-1:0]            slice_data,
    output logic                          slice_valid,
    input  logic                          slice_ready,
    output logic                          frame_start,
    output logic                          frame_end
);

    localparam int              c_BITS     = LEDS * BPP;
    localparam int              c_IW       = $clog2(c_BITS);
    localparam int              c_GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(c_BITS - 1);
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'(GAP_CYCLES - 1);

    led_wall_pkg::state_t r_state, w_nxt_state;
    logic                 r_front, w_nxt_front;
    logic [c_IW-1:0]      r_idx, w_nxt_idx;
    logic [c_GW-1:0]      r_gap, w_nxt_gap;
    logic                 r_pending, w_nxt_pending;
    logic                 w_nxt_valid;
    logic                 w_apply;
    logic [STRANDS-1:0]   w_col0, w_col1, w_col;
    logic [STRANDS-1:0]   r_slice_data;
    logic                 r_slice_valid, r_frame_start, r_frame_end;

    // r_front selects the bank being streamed; writes go to the other one
    frame_bank #(.STRANDS(STRANDS), .LEDS(LEDS), .BPP(BPP)) u_bank0 (
        .clk_in    (clk_in),
        .ar        (ar),
        .wr_en     (wr_en && r_front),
        .wr_strand (wr_strand),
        .wr_led    (wr_led),
        .wr_grb    (wr_grb),
        .rd_idx    (w_nxt_idx),
        .rd_col    (w_col0)
    );

    frame_bank #(.STRANDS(STRANDS), .LEDS(LEDS), .BPP(BPP)) u_bank1 (
        .clk_in    (clk_in),
        .ar        (ar),
        .wr_en     (wr_en && !r_front),
        .wr_strand (wr_strand),
        .wr_led    (wr_led),
        .wr_grb    (wr_grb),
        .rd_idx    (w_nxt_idx),
        .rd_col    (w_col1)
    );

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_gap   = r_gap;
        w_nxt_valid = r_slice_valid;
        w_apply     = 1'b0;
        case (r_state)
            led_wall_pkg::IDLE: begin
                if (r_pending) begin
                    w_apply     = 1'b1;
                    w_nxt_state = led_wall_pkg::STREAM;
                    w_nxt_idx   = c_IDX_LAST;
                    w_nxt_valid = 1'b1;
                end
            end
            led_wall_pkg::STREAM: begin
                if (r_slice_valid && slice_ready) begin
                    if (r_idx == '0) begin
                        w_nxt_state = led_wall_pkg::GAP;
                        w_nxt_valid = 1'b0;
                        w_nxt_gap   = c_GAP_LAST;
                    end else begin
                        w_nxt_idx = r_idx - 1'b1;
                    end
                end
            end
            led_wall_pkg::GAP: begin
                if (r_gap == '0) begin
                    w_apply     = r_pending;
                    w_nxt_state = led_wall_pkg::STREAM;
                    w_nxt_idx   = c_IDX_LAST;
                    w_nxt_valid = 1'b1;
                end else begin
                    w_nxt_gap = r_gap - 1'b1;
                end
            end
            default: w_nxt_state = led_wall_pkg::IDLE;
        endcase
        w_nxt_front   = w_apply ? !r_front : r_front;
        w_nxt_pending = w_apply ? 1'b0 : (r_pending || swap_req);
        // Read the column the outputs will show next, from the bank that will be front
        w_col         = w_nxt_front ? w_col1 : w_col0;
    end

    always_ff @(posedge clk_in) begin
        if (!ar) begin
            r_state       <= led_wall_pkg::IDLE;
            r_front       <= 1'b0;
            r_idx         <= c_IDX_LAST;
            r_gap         <= '0;
            r_pending     <= 1'b0;
            r_slice_data  <= '0;
            r_slice_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_front       <= w_nxt_front;
            r_idx         <= w_nxt_idx;
            r_gap         <= w_nxt_gap;
            r_pending     <= w_nxt_pending;
            r_slice_data  <= w_nxt_valid ? w_col : '0;
            r_slice_valid <= w_nxt_valid;
            r_frame_start <= w_nxt_valid && (w_nxt_idx == c_IDX_LAST);
            r_frame_end   <= w_nxt_valid && (w_nxt_idx == '0);
        end
    end

    assign swap_pending = r_pending;
    assign slice_data   = r_slice_data;
    assign slice_valid  = r_slice_valid;
    assign frame_start  = r_frame_start;
    assign frame_end    = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_frame_slicer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_slicer
// Purpose  : Directed self-checking bench for frame_slicer (GAP_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_slicer;

    localparam int BITS = 120;
    localparam int GAP  = 4;

    logic        clk = 1'b0;
    logic        ar;
    logic        wr_en;
    logic [2:0]  wr_strand;
    logic [2:0]  wr_led;
    logic [23:0] wr_grb;
    logic        swap_req;
    logic        swap_pending;
    logic [7:0]  slice_data;
    logic        slice_valid;
    logic        slice_ready;
    logic        frame_start;
    logic        frame_end;

    int chk  = 0;
    int pass = 0;

    logic [23:0] known_led [5] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFF0000, 24'hFFFFFF};

    always #5 clk = ~clk;

    frame_slicer #(.GAP_CYCLES(GAP)) dut (
        .clk_in       (clk),
        .ar           (ar),
        .wr_en        (wr_en),
        .wr_strand    (wr_strand),
        .wr_led       (wr_led),
        .wr_grb       (wr_grb),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .slice_data   (slice_data),
        .slice_valid  (slice_valid),
        .slice_ready  (slice_ready),
        .frame_start  (frame_start),
        .frame_end    (frame_end)
    );

    // Hand-derived slice pattern of the known frame on strands 0 and 1
    function automatic logic [7:0] exp_known(input int k);
        int led;
        int b;
        led = k / 24;
        b   = k % 24;
        case (led)
            0, 3:    return (b < 8) ? 8'h03 : 8'h00;
            1:       return (b >= 8 && b < 16) ? 8'h03 : 8'h00;
            2:       return (b >= 16) ? 8'h03 : 8'h00;
            default: return 8'h03;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input int s, input int l, input logic [23:0] v);
        wr_en     = 1'b1;
        wr_strand = 3'(s);
        wr_led    = 3'(l);
        wr_grb    = v;
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (slice_valid && frame_start) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk++;
        if (!ok) $display("FAIL %s frame_start timeout got 0 want 1", name);
        else pass++;
    endtask

    task automatic test_reset();
        ar = 1'b0; wr_en = 1'b0; wr_strand = '0; wr_led = '0; wr_grb = '0;
        swap_req = 1'b0; slice_ready = 1'b1;
        repeat (3) tick();
        chk++; if (slice_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", slice_valid); else pass++;
        chk++; if (slice_data !== 8'h00) $display("FAIL reset_data got %h want 00", slice_data); else pass++;
        chk++; if (frame_start !== 1'b0) $display("FAIL reset_start got %b want 0", frame_start); else pass++;
        chk++; if (frame_end !== 1'b0) $display("FAIL reset_end got %b want 0", frame_end); else pass++;
        chk++; if (swap_pending !== 1'b0) $display("FAIL reset_pending got %b want 0", swap_pending); else pass++;
        ar = 1'b1;
        tick();
    endtask

    task automatic test_known_frame();
        logic [10:0] e;
        for (int s = 0; s < 8; s++)
            for (int l = 0; l < 5; l++)
                write_px(s, l, (s < 2) ? known_led[l] : 24'h0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk++; if ({swap_pending, slice_valid} !== 2'b10)
            $display("FAIL swap_lat1 got pend/valid %b want 10", {swap_pending, slice_valid}); else pass++;
        tick();
        chk++; if ({swap_pending, slice_valid} !== 2'b01)
            $display("FAIL swap_lat2 got pend/valid %b want 01", {swap_pending, slice_valid}); else pass++;
        for (int k = 0; k < BITS; k++) begin
            e = {1'b1, k == 0, k == BITS - 1, exp_known(k)};
            chk++; if ({slice_valid, frame_start, frame_end, slice_data} !== e)
                $display("FAIL known k=%0d got %h want %h", k, {slice_valid, frame_start, frame_end, slice_data}, e);
            else pass++;
            tick();
        end
    endtask

    task automatic test_gap();
        int low;
        low = 0;
        while (!slice_valid && low < 50) begin
            low++;
            tick();
        end
        chk++; if (low != GAP) $display("FAIL gap_len got %0d want %0d", low, GAP); else pass++;
        chk++; if ({slice_valid, frame_start, slice_data} !== {2'b11, 8'h03})
            $display("FAIL gap_repeat got %h want %h", {slice_valid, frame_start, slice_data}, {2'b11, 8'h03});
        else pass++;
    endtask

    task automatic test_backpressure();
        logic [10:0] e;
        for (int k = 0; k < 19; k++) tick();
        slice_ready = 1'b0;
        e = {1'b1, 1'b0, 1'b0, exp_known(19)};
        for (int i = 0; i < 5; i++) begin
            tick();
            chk++; if ({slice_valid, frame_start, frame_end, slice_data} !== e)
                $display("FAIL bp_hold i=%0d got %h want %h", i, {slice_valid, frame_start, frame_end, slice_data}, e);
            else pass++;
        end
        slice_ready = 1'b1;
        for (int k = 19; k < BITS; k++) begin
            e = {1'b1, 1'b0, k == BITS - 1, exp_known(k)};
            chk++; if ({slice_valid, frame_start, frame_end, slice_data} !== e)
                $display("FAIL bp_seq k=%0d got %h want %h", k, {slice_valid, frame_start, frame_end, slice_data}, e);
            else pass++;
            tick();
        end
    endtask

    task automatic test_midframe_swap();
        wait_start("mid");
        for (int k = 0; k < 59; k++) tick();
        // Stall while refilling the back bank so the new frame keeps strands 0/1
        slice_ready = 1'b0;
        for (int s = 0; s < 2; s++)
            for (int l = 0; l < 5; l++)
                write_px(s, l, known_led[l]);
        wr_en = 1'b1; wr_strand = 3'd7; wr_led = 3'd0; wr_grb = 24'hFFFFFF;
        swap_req = 1'b1;
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        chk++; if (swap_pending !== 1'b1) $display("FAIL mid_pend got %b want 1", swap_pending); else pass++;
        slice_ready = 1'b1;
        for (int k = 59; k < BITS; k++) begin
            chk++; if ({slice_valid, swap_pending, slice_data} !== {2'b11, exp_known(k)})
                $display("FAIL mid_old k=%0d got %h want %h", k, {slice_valid, swap_pending, slice_data}, {2'b11, exp_known(k)});
            else pass++;
            tick();
        end
        for (int g = 0; g < GAP; g++) begin
            chk++; if ({slice_valid, swap_pending} !== 2'b01)
                $display("FAIL mid_gap g=%0d got %b want 01", g, {slice_valid, swap_pending}); else pass++;
            tick();
        end
        chk++; if ({slice_valid, frame_start, swap_pending, slice_data} !== {3'b110, 8'h83})
            $display("FAIL mid_new got %h want %h", {slice_valid, frame_start, swap_pending, slice_data}, {3'b110, 8'h83});
        else pass++;
    endtask

    task automatic test_ignored_coincident();
        bit          ok;
        logic [7:0]  e;
        write_px(2, 5, 24'hFFFFFF);
        wr_en = 1'b1; wr_strand = 3'd4; wr_led = 3'd0; wr_grb = 24'h800000;
        swap_req = 1'b1;
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (slice_valid && frame_start && !swap_pending) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk++; if (!ok) $display("FAIL coin_wait timeout got 0 want 1"); else pass++;
        for (int k = 0; k < BITS; k++) begin
            e = exp_known(k) | ((k == 0) ? 8'h10 : 8'h00);
            chk++; if (slice_data !== e)
                $display("FAIL coin k=%0d got %h want %h", k, slice_data, e); else pass++;
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        int hi;
        wait_start("rst");
        for (int k = 0; k < 59; k++) tick();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk++; if (swap_pending !== 1'b1) $display("FAIL rst_pend_set got %b want 1", swap_pending); else pass++;
        for (int k = 60; k < 69; k++) tick();
        ar = 1'b0;
        tick();
        ar = 1'b1;
        chk++; if ({slice_valid, swap_pending, frame_start, frame_end, slice_data} !== 12'h000)
            $display("FAIL rst_mid got %h want 000", {slice_valid, swap_pending, frame_start, frame_end, slice_data});
        else pass++;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (slice_valid || swap_pending) hi++;
        end
        chk++; if (hi != 0) $display("FAIL rst_idle got %0d active cycles want 0", hi); else pass++;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        for (int k = 0; k < BITS; k++) begin
            chk++; if ({slice_valid, frame_start, frame_end, slice_data} !== {1'b1, k == 0, k == BITS - 1, 8'h00})
                $display("FAIL rst_zero k=%0d got %h want %h", k, {slice_valid, frame_start, frame_end, slice_data},
                         {1'b1, k == 0, k == BITS - 1, 8'h00});
            else pass++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_known_frame();
        test_gap();
        test_backpressure();
        test_midframe_swap();
        test_ignored_coincident();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/frame_slicer.md
# frame_slicer

Double-buffered frame store that sits directly upstream of the shift-register controller in the LED wall datapath. It accepts per-LED 24-bit GRB writes for 8 strands into a back bank. On request, it swaps that bank to the front at a frame boundary. It streams the front bank out as 8-bit strand slices, one bit per strand per beat, under a valid/ready handshake. After every frame it inserts a programmable latch/reset gap.

## Interface
Parameters:
- STRANDS, 8, number of parallel strands; also the slice width.
- LEDS, 5, LEDs per strand.
- BPP, 24, bits per LED, in order G[7:0], R[7:0], B[7:0].
- GAP_CYCLES, 1000, idle beats between frames (50 µs at 20 MHz).

Ports:
- clk_in, in, 1, single clock; all logic is on its rising edge.
- ar, in, 1, synchronous active-low reset.
- wr_en, in, 1, write strobe.
- wr_strand, in, $clog2(STRANDS), target strand.
- wr_led, in, $clog2(LEDS), target LED index.
- wr_grb, in, BPP, pixel value as {G,R,B}.
- swap_req, in, 1, one-cycle pulse requesting a back→front swap.
- swap_pending, out, 1, swap requested but not yet applied.
- slice_data, out, STRANDS, bit n of each strand; bit s = strand s.
- slice_valid, out, 1, slice_data is valid.
- slice_ready, in, 1, downstream accepts a slice.
- frame_start, out, 1, qualifies the first slice of a frame.
- frame_end, out, 1, qualifies the last slice of a frame.

## Operation
- Each strand holds BITS = LEDS*BPP bits (120 by default), packed with LED0 at the MSBs: bits [BITS-1 -: BPP] are LED0, and within an LED G[7] is the MSB.
- Streaming order is bit index BITS-1 down to 0. This order is LED0 G7 first and last-LED B0 last.
- Writes always target the back bank. A write with wr_led ≥ LEDS is ignored.
- swap_req sets swap_pending. Further swap_req pulses while pending have no additional effect.
- Writes issued while pending still land in the back bank and are included in the swap.
- A write and a swap in the same cycle: the write is included in the swap.
- State machine states: IDLE, STREAM, GAP.
  - IDLE → STREAM when swap_pending. That edge flips the front bank, clears swap_pending, loads idx=BITS-1 and raises slice_valid.
  - STREAM: a beat is accepted when slice_valid && slice_ready, and each accepted beat decrements idx.
  - STREAM → GAP on acceptance at idx=0. That edge drops slice_valid and loads the gap counter with GAP_CYCLES-1.
  - GAP: the counter decrements each cycle. When it reaches 0, the block applies the swap if pending, then goes to STREAM with idx=BITS-1.
  - Without a new swap, the front frame refreshes forever.
- Swaps apply only at the IDLE exit or the GAP exit, never mid-frame.
- frame_start = slice_valid && idx==BITS-1. frame_end = slice_valid && idx==0.

## Timing
- Reset values:
  - State: IDLE, front bank = 0, idx = BITS-1.
  - Both banks: all zeros.
  - slice_valid, frame_start, frame_end, swap_pending: 0. slice_data: 0.
- slice_data, slice_valid, frame_start and frame_end are registered.
- While slice_valid && !slice_ready, all four hold stable.
- Latency from swap_req in IDLE:
  - swap_pending is 1 in cycle +1.
  - The first valid slice appears in cycle +2, with swap_pending back at 0.
- Frame period with ready tied high: BITS + GAP_CYCLES cycles.
- slice_valid is low for exactly GAP_CYCLES cycles between frames.
- Reset asserted mid-frame takes effect at the next edge. All outputs return to reset values and any pending swap is lost.

## Structure
- Shared package led_wall_pkg holds:
  - STRANDS, LEDS, BPP, BITS.
  - The state enum (IDLE, STREAM, GAP).
- frame_slicer itself holds the FSM, idx, gap counter and output registers.
- Sub-module frame_bank is instanced twice. It provides:
  - STRANDS × BITS register storage.
  - A write port by (strand, led).
  - A combinational column read of bit idx across all strands.

## Test plan
- Known frame:
  - Stimulus: write strands 0 and 1 with LEDs 0xFF0000, 0x00FF00, 0x0000FF, 0xFF0000, 0xFFFFFF; write other strands 0; swap; ready high.
  - Expected slices:
    - LED0: 8×0x03, 16×0x00.
    - LED1: 8×0x00, 8×0x03, 8×0x00.
    - LED2: 16×0x00, 8×0x03.
    - LED3: same as LED0.
    - LED4: 24×0x03.
  - Flags: frame_start on slice 1 only; frame_end on slice 120 only.
- Backpressure: drop slice_ready for 5 cycles at idx=100. slice_data and slice_valid hold for those cycles, and no slice is skipped or duplicated.
- Gap: with GAP_CYCLES=4 and ready high, slice_valid is low exactly 4 cycles after frame_end. The next frame_start repeats the same data.
- Mid-frame swap:
  - Stimulus: write strand 7 LED0=0xFFFFFF and pulse swap_req during slice 60.
  - Expected: the remaining 60 slices keep old data and swap_pending stays 1 through the gap. The next frame's first slice is 0x83, and swap_pending clears.
- Ignored write and coincident write+swap:
  - Stimulus: write wr_led=5 to strand 2 with 0xFFFFFF; in the same cycle as swap_req, write strand 4 LED0=0x800000.
  - Expected: strand 2 stays all-zero. The first slice of the swapped frame has bit 4 = 1.
- Reset mid-stream:
  - Stimulus: assert ar low at idx=50 for one cycle.
  - Expected: next cycle slice_valid=0 and swap_pending=0. The block stays in IDLE with zeroed banks until a new swap_req.
